// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Used by prog_loader; see its header for the checksum build option.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    HOLD,
    RUN,
    ERR
  } loader_state_t;

  localparam int MIN_PROG_WORDS = 1;

endpackage

// File: rtl/prog_loader.sv
// Boot loader: framed word stream into instruction RAM, CPU held in reset.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing sum-of-payload word.
module prog_loader #(
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_W     = $clog2(MEM_DEPTH),
  parameter int RESET_HOLD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  import prog_loader_pkg::*;

  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  loader_state_t   state_q;
  loader_state_t   state_d;
  logic            rdy_q;
  logic [ADDR_W:0] n_q;
  logic [ADDR_W:0] wc_nxt;
  logic [HW-1:0]   hold_q;
  logic            fire;
  logic            hdr_bad;
  logic            last_pay;
  logic            pay_bad;
  logic            wr;

  assign fire     = in_valid && rdy_q;
  assign wc_nxt   = word_count + 1'b1;
  assign last_pay = (wc_nxt == n_q);
  assign hdr_bad  = (in_data < MIN_PROG_WORDS) ||
                    (in_data > MEM_DEPTH);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;

  // With a checksum, no payload word may carry in_last.
  assign pay_bad = in_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else if (wr) begin
      sum_q <= sum_q + in_data;
    end
  end
`else
  assign pay_bad = (in_last != last_pay);
`endif

  assign wr = fire && (state_q == LOAD) && !pay_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= state_d inside {IDLE, LOAD, CHECK};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = (hdr_bad || in_last) ? ERR : LOAD;
        end
      end
      LOAD: begin
        if (fire) begin
          if (pay_bad) begin
            state_d = ERR;
          end else if (last_pay) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = HOLD;
`endif
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK: begin
        if (fire) begin
          // A missing in_last wins over the sum compare.
          if (!in_last || (in_data != sum_q)) begin
            state_d = ERR;
          end else begin
            state_d = HOLD;
          end
        end
      end
`endif
      HOLD: begin
        if (hold_q == '0) begin
          state_d = RUN;
        end
      end
      RUN: state_d = RUN;
      ERR: state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_comb begin
    in_ready  = rdy_q;
    cpu_reset = (state_q != RUN);
    done      = (state_q == RUN);
    error     = (state_q == ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      n_q        <= '0;
      hold_q     <= '0;
    end else begin
      imem_we <= wr;
      if (wr) begin
        imem_addr  <= word_count[ADDR_W-1:0];
        imem_wdata <= in_data;
        word_count <= wc_nxt;
      end
      if ((state_q == IDLE) && fire) begin
        n_q <= in_data[ADDR_W:0];
      end
      if ((state_d == HOLD) && (state_q != HOLD)) begin
        hold_q <= HW'(RESET_HOLD - 1);
      end else if (state_q == HOLD) begin
        hold_q <= hold_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a frame-level model.
// Honours PROG_LOADER_CHECKSUM_EN to build frames with a checksum word.
module tb_prog_loader;

  localparam int MEM_DEPTH  = 1024;
  localparam int ADDR_W     = 10;
  localparam int RESET_HOLD = 2;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_data = '0;
  logic              in_last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  prog_loader #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_W(ADDR_W),
    .RESET_HOLD(RESET_HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset),
    .done(done),
    .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];

  always @(negedge clk) begin
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 64'(in_ready), 64'd1);
    end else begin
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic bubble(input bit en);
    if (en) begin
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_we"}, 64'(imem_we), 64'd0);
    chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_wc"}, 64'(word_count), 64'd0);
  endtask

  // lastpos < 0: in_last only on the final word; otherwise only at lastpos.
  task automatic run_frame(input string tag, input int n,
                           input logic [31:0] pay[$], input int lastpos,
                           input bit badck, input bit bub);
    logic [31:0] w[$];
    bit          l[$];
    logic [31:0] sum;
    int          len;
    int          f;
    int          consumed;
    int          exp_wr;
    bit          exp_err;
    w.push_back(32'(n));
    sum = '0;
    if (n >= 1 && n <= MEM_DEPTH) begin
      for (int i = 0; i < n; i++) begin
        w.push_back(pay[i]);
        sum += pay[i];
      end
      if (CK == 1) w.push_back(badck ? sum + 32'd1 : sum);
    end
    len = w.size();
    for (int i = 0; i < len; i++) begin
      l.push_back(lastpos < 0 ? (i == len - 1) : (i == lastpos));
    end
    f = -1;
    for (int i = len - 1; i >= 0; i--) if (l[i]) f = i;
    if (n < 1 || n > MEM_DEPTH) begin
      exp_err = 1; consumed = 1; exp_wr = 0;
    end else if (f >= 0 && f < len - 1) begin
      exp_err = 1; consumed = f + 1; exp_wr = (f > 0) ? f - 1 : 0;
    end else if (f < 0) begin
      exp_err = 1; consumed = len; exp_wr = (CK == 1) ? n : n - 1;
    end else if (CK == 1 && badck) begin
      exp_err = 1; consumed = len; exp_wr = n;
    end else begin
      exp_err = 0; consumed = len; exp_wr = n;
    end
    for (int i = 0; i < consumed; i++) begin
      bubble(bub);
      send(w[i], l[i]);
    end
    if (exp_err) begin
      chk({tag, "_err_next"}, 64'(error), 64'd1);
      chk({tag, "_rdy_drop"}, 64'(in_ready), 64'd0);
      chk({tag, "_no_bad_we"}, 64'(imem_we), 64'd0);
    end
    repeat (RESET_HOLD + 2) tick();
    chk({tag, "_error"}, 64'(error), 64'(exp_err));
    chk({tag, "_done"}, 64'(done), 64'(!exp_err));
    chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(exp_err));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_wc"}, 64'(word_count), 64'(exp_wr));
    chk({tag, "_nwr"}, 64'(wa_q.size()), 64'(exp_wr));
    for (int i = 0; i < exp_wr && i < wa_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(wa_q[i]), 64'(i));
      chk($sformatf("%s_data%0d", tag, i), 64'(wd_q[i]), 64'(pay[i]));
    end
  endtask

  task automatic rand_pay(input int n, output logic [31:0] p[$]);
    p.delete();
    for (int i = 0; i < n; i++) p.push_back($urandom);
  endtask

  initial begin
    logic [31:0] p[$];
    int          n;
    int          lp;

    repeat (2) tick();
    check_reset_values("rst");
    reset = 1'b0;
    tick();
    chk("rdy_after_rst", 64'(in_ready), 64'd1);
    wa_q.delete();
    wd_q.delete();

    // Directed load with exact write/release timing.
    p = '{32'h20080008, 32'h20090007, 32'h01095020, 32'h010B5822};
    send(32'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(p[i], (CK == 0) && (i == 3));
      chk($sformatf("dir_we%0d", i), 64'(imem_we), 64'd1);
      chk($sformatf("dir_addr%0d", i), 64'(imem_addr), 64'(i));
      chk($sformatf("dir_data%0d", i), 64'(imem_wdata), 64'(p[i]));
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send(p[0] + p[1] + p[2] + p[3], 1'b1);
    chk("dir_ck_we", 64'(imem_we), 64'd0);
`endif
    chk("dir_rel_t1", 64'(cpu_reset), 64'd1);
    tick();
    chk("dir_rel_t2", 64'(cpu_reset), 64'd1);
    tick();
    chk("dir_rel_t3", 64'(cpu_reset), 64'd0);
    chk("dir_done", 64'(done), 64'd1);
    chk("dir_wc", 64'(word_count), 64'd4);
    chk("dir_nwr", 64'(wa_q.size()), 64'd4);
    chk("dir_rdy_run", 64'(in_ready), 64'd0);

    do_reset();
    p.delete();
    run_frame("hdr0", 0, p, -1, 0, 0);
    do_reset();
    run_frame("hdr1025", MEM_DEPTH + 1, p, -1, 0, 0);
    do_reset();
    rand_pay(3, p);
    run_frame("hdr_last", 3, p, 0, 0, 0);

    do_reset();
    rand_pay(4, p);
    run_frame("early_last", 4, p, 3, 0, 0);
    do_reset();
    rand_pay(4, p);
    run_frame("no_last", 4, p, 999, 0, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
    do_reset();
    p = '{32'h1, 32'h2};
    run_frame("ck_good", 2, p, -1, 0, 0);
    do_reset();
    run_frame("ck_bad", 2, p, -1, 1, 0);
    do_reset();
    run_frame("ck_nolast", 2, p, 999, 0, 0);
`endif

    do_reset();
    rand_pay(1, p);
    run_frame("n1", 1, p, -1, 0, 0);
    do_reset();
    rand_pay(16, p);
    run_frame("bub16", 16, p, -1, 0, 1);
    do_reset();
    rand_pay(MEM_DEPTH, p);
    run_frame("nmax", MEM_DEPTH, p, -1, 0, 0);

    for (int r = 0; r < 8; r++) begin
      do_reset();
      n = $urandom_range(1, 24);
      rand_pay(n, p);
      lp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n + CK + 1) : -1;
      run_frame($sformatf("rnd%0d", r), n, p, lp, 0, 1);
    end

    // Reset mid-frame, then a fresh frame.
    do_reset();
    rand_pay(8, p);
    send(32'd8, 1'b0);
    for (int i = 0; i < 3; i++) send(p[i], 1'b0);
    reset = 1'b1;
    tick();
    check_reset_values("mid_rst");
    reset = 1'b0;
    tick();
    chk("mid_rdy", 64'(in_ready), 64'd1);
    wa_q.delete();
    wd_q.delete();
    rand_pay(2, p);
    run_frame("post_rst", 2, p, -1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
